// File: rtl/div_unit_if.sv
// Issue/response bundle between the EX stage and the iterative divider.
// The EX stage drives the request side; the divider returns busy/done/result.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       select;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, select, data1, data2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, select, data1, data2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Divide-by-zero and signed overflow bypass the iteration and finish immediately.
module div_unit #(
  parameter int         WIDTH   = 32,
  parameter logic [4:0] OP_DIV  = 5'd12,
  parameter logic [4:0] OP_DIVU = 5'd13,
  parameter logic [4:0] OP_REM  = 5'd14,
  parameter logic [4:0] OP_REMU = 5'd15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_result;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_is_rem;

  logic             w_is_div_op;
  logic             w_signed_op;
  logic             w_rem_op;
  logic             w_accept;
  logic             w_div_zero;
  logic             w_overflow;
  logic             w_special;
  logic [WIDTH-1:0] w_special_res;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quot_next;
  logic [WIDTH-1:0] w_final;
  logic             w_last;
  logic             w_busy;
  logic             w_done;

  // Request decode and corner-case detection on the live inputs.
  assign w_is_div_op = (bus.select == OP_DIV) || (bus.select == OP_DIVU) ||
                       (bus.select == OP_REM) || (bus.select == OP_REMU);
  assign w_signed_op = (bus.select == OP_DIV) || (bus.select == OP_REM);
  assign w_rem_op    = (bus.select == OP_REM) || (bus.select == OP_REMU);
  assign w_accept    = (r_state != CALC) && bus.start && w_is_div_op;
  assign w_div_zero  = (bus.data2 == '0);
  assign w_overflow  = w_signed_op && (bus.data1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
                       (bus.data2 == '1);
  assign w_special   = w_div_zero || w_overflow;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = w_rem_op ? bus.data1 : '1;
    else if (!w_rem_op)
      w_special_res = {1'b1, {(WIDTH-1){1'b0}}};
  end

  assign w_a_neg = w_signed_op && bus.data1[WIDTH-1];
  assign w_b_neg = w_signed_op && bus.data2[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~bus.data1 + 1'b1) : bus.data1;
  assign w_b_mag = w_b_neg ? (~bus.data2 + 1'b1) : bus.data2;

  // One restoring step: shift rem:quot left, trial-subtract, keep on no borrow.
  assign w_shift     = {r_rem, r_quot[WIDTH-1]};
  assign w_sub       = w_shift - {1'b0, r_divisor};
  assign w_ge        = (w_shift >= {1'b0, r_divisor});
  assign w_rem_next  = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quot_next = {r_quot[WIDTH-2:0], w_ge};
  assign w_last      = (r_count == CW'(WIDTH-1));

  always_comb begin
    if (r_is_rem)
      w_final = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
    else
      w_final = r_neg_q ? (~w_quot_next + 1'b1) : w_quot_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, FIN: begin
        if (w_accept)
          w_state_next = w_special ? FIN : CALC;
        else
          w_state_next = IDLE;
      end
      CALC:    w_state_next = w_last ? FIN : CALC;
      default: w_state_next = IDLE;
    endcase
    if (bus.flush)
      w_state_next = IDLE;
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      CALC:    w_busy = 1'b1;
      FIN:     w_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath; a flush freezes everything so RESULT keeps its last value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count   <= '0;
      r_divisor <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_result  <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
    end else if (!bus.flush) begin
      if (w_accept) begin
        r_divisor <= w_b_mag;
        r_quot    <= w_a_mag;
        r_rem     <= '0;
        r_count   <= '0;
        r_neg_q   <= w_a_neg ^ w_b_neg;
        r_neg_r   <= w_a_neg;
        r_is_rem  <= w_rem_op;
        if (w_special)
          r_result <= w_special_res;
      end else if (r_state == CALC) begin
        r_rem   <= w_rem_next;
        r_quot  <= w_quot_next;
        r_count <= r_count + 1'b1;
        if (w_last)
          r_result <= w_final;
      end
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;

endmodule
